compress_sequencer: RTL and testbench
=====================================

Name: compress_sequencer

Overview:
- Clk-domain controller that sequences one 28x28→32x32 image compression per CPU request.
- CPU writes 1 to the compress control register (C008). The block arms and waits for a frame boundary, optionally skipping frames so exposure can settle. It then pulses compressor start, counts image-memory write strobes to detect completion, and clears the request bit that the CPU polls.
- Adds a timeout, abort, pause and a sticky error flag so a stalled compressor cannot hang the CPU polling loop.

Parameters:
- NUM_PIXELS, 1024, image_mem writes that constitute one complete compressed image.
- TIMEOUT_CYCLES, 2000000, max clk cycles allowed in RUN before abort (40 ms at 50 MHz).
- SKIP_FRAMES, 0, frame_start pulses ignored after arming before start is issued.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_we  in  1  CPU write strobe to C008, single cycle.
- ctrl_wdata  in  1  CPU write data bit 0: 1 = request, 0 = abort.
- frame_start  in  1  one-cycle pulse at VGA frame start, already synchronized to clk.
- pause_n  in  1  synchronized; 0 holds off issuing a new start.
- pix_wr  in  1  one-cycle pulse per image_mem write, already synchronized to clk.
- compress_start  out  1  one-cycle pulse to the compressor.
- compress_req  out  1  status bit read at C008; 1 from accepted request until finish, abort or timeout.
- busy  out  1  1 while in START or RUN.
- done  out  1  one-cycle pulse on successful completion.
- err_timeout  out  1  sticky timeout flag.
- status  out  32  {29'b0, err_timeout, busy, compress_req} for CPU readback.

Behaviour:
- Reset (async, rst_n=0) values:
  - State IDLE.
  - compress_start=0, compress_req=0, busy=0, done=0, err_timeout=0.
  - All counters 0.
- States: IDLE, ARM, START, RUN. Registered outputs update the cycle after the causing event.
- IDLE:
  - ctrl_we&ctrl_wdata=1 → ARM. compress_req=1 and err_timeout=0 the next cycle; skip_cnt loads SKIP_FRAMES.
  - ctrl_we with wdata=0: no effect.
- ARM:
  - frame_start with skip_cnt≠0 → skip_cnt decrements.
  - frame_start with skip_cnt=0 and pause_n=1 → START.
  - frame_start while pause_n=0 is ignored and does not decrement skip_cnt.
  - No timeout in ARM.
- START:
  - compress_start=1 for exactly this one cycle.
  - pix_cnt and tmo_cnt cleared; next state RUN unconditionally.
  - pix_wr arriving in the START cycle is counted.
- RUN:
  - Each pix_wr increments pix_cnt (width $clog2(NUM_PIXELS+1)). tmo_cnt increments every cycle.
  - pix_wr that brings pix_cnt to NUM_PIXELS → IDLE; done=1 for one cycle; compress_req=0.
  - tmo_cnt reaching TIMEOUT_CYCLES-1 without completion → IDLE; err_timeout=1 (sticky); compress_req=0; no done.
  - pix_wr after completion (in IDLE) is ignored.
- Abort: ctrl_we with wdata=0 in ARM/START/RUN → IDLE next cycle; compress_req=0; no done; err_timeout unchanged.
- Write 1 while not IDLE: ignored. No re-arm, no counter reset.
- Simultaneous events (same cycle):
  - Completing pix_wr + abort write → completion wins (done pulses).
  - Completing pix_wr + timeout → completion wins.
  - Abort + timeout → abort wins (no error).
- Reset mid-operation: immediate return to IDLE with all outputs 0. Any compressor already started is not signalled.
- busy = (state==START)|(state==RUN).
- status is combinational from the registered flags.

Test Plan:
- Reset, write 1, pulse frame_start, issue 1024 pix_wr:
  - compress_req=1 the cycle after the write.
  - compress_start is a single pulse one cycle after frame_start.
  - done pulses on the 1024th strobe; compress_req=0; status=0.
- SKIP_FRAMES=2, write 1, three frame_start pulses:
  - No start on pulses 1–2.
  - compress_start follows pulse 3.
- Write 1, pause_n=0, two frame_start pulses, then pause_n=1 and one more frame_start:
  - No start while paused.
  - Exactly one start after the final pulse.
- TIMEOUT_CYCLES=100, arm and start, send 10 pix_wr:
  - Timeout after 100 RUN cycles; compress_req=0, err_timeout=1, no done.
  - A new write 1 clears err_timeout.
- In RUN after 500 strobes, write 0:
  - IDLE next cycle, compress_req=0, no done.
  - Repeat with the abort in the same cycle as the 1024th strobe → done=1.
- Deassert rst_n mid-RUN → all outputs 0 asynchronously. After release, a write 1 during the old sequence's trailing pix_wr pulses sees pix_cnt start at 0 after the next START.

Source files
------------

// File: rtl/compress_sequencer.sv
// compress_sequencer: arms on a CPU request, waits for a frame boundary, starts the compressor
// and tracks completion by counting image-memory writes, with abort, pause and timeout.
module compress_sequencer #(
   parameter int NUM_PIXELS     = 1024,
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int SKIP_FRAMES    = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ctrl_we,
   input  logic        ctrl_wdata,
   input  logic        frame_start,
   input  logic        pause_n,
   input  logic        pix_wr,
   output logic        compress_start,
   output logic        compress_req,
   output logic        busy,
   output logic        done,
   output logic        err_timeout,
   output logic [31:0] status
);
   localparam int PW = $clog2(NUM_PIXELS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SW = SKIP_FRAMES > 0 ? $clog2(SKIP_FRAMES + 1) : 1;
   typedef enum logic [1:0] {IDLE, ARM, START, RUN} state_t;
   state_t state;
   logic [PW-1:0] pix_cnt;
   logic [PW-1:0] pix_base;
   logic [TW-1:0] tmo_cnt;
   logic [SW-1:0] skip_cnt;
   logic req_wr;
   logic abort_wr;
   logic finish;
   logic timeout;
   assign req_wr   = ctrl_we & ctrl_wdata;
   assign abort_wr = ctrl_we & ~ctrl_wdata;
   // the START cycle counts from zero so a strobe landing there is not lost
   assign pix_base = (state == START) ? '0 : pix_cnt;
   assign finish   = pix_wr && (pix_base == PW'(NUM_PIXELS - 1));
   assign timeout  = (state == RUN) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
   assign status   = {29'b0, err_timeout, busy, compress_req};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pix_cnt        <= '0;
         tmo_cnt        <= '0;
         skip_cnt       <= '0;
         compress_start <= 1'b0;
         compress_req   <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         compress_start <= 1'b0;
         done           <= 1'b0;
         case (state)
            IDLE: if (req_wr) begin
               state        <= ARM;
               compress_req <= 1'b1;
               err_timeout  <= 1'b0;
               skip_cnt     <= SW'(SKIP_FRAMES);
            end
            ARM: if (abort_wr) begin
               state        <= IDLE;
               compress_req <= 1'b0;
            end else if (frame_start && pause_n) begin
               if (skip_cnt != '0) skip_cnt <= skip_cnt - SW'(1);
               else begin
                  state          <= START;
                  compress_start <= 1'b1;
                  busy           <= 1'b1;
               end
            end
            START, RUN: begin
               pix_cnt <= pix_base + PW'(pix_wr);
               tmo_cnt <= (state == START) ? '0 : tmo_cnt + TW'(1);
               // completion beats abort, abort beats timeout
               if (finish) begin
                  state        <= IDLE;
                  done         <= 1'b1;
                  compress_req <= 1'b0;
                  busy         <= 1'b0;
               end else if (abort_wr) begin
                  state        <= IDLE;
                  compress_req <= 1'b0;
                  busy         <= 1'b0;
               end else if (timeout) begin
                  state        <= IDLE;
                  compress_req <= 1'b0;
                  busy         <= 1'b0;
                  err_timeout  <= 1'b1;
               end else state <= RUN;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_compress_sequencer.sv
// tb_compress_sequencer: randomized directed scenarios checked every cycle against a
// behavioural model of the request/skip/pixel-count/timeout rules.
module tb_compress_sequencer;
   localparam int NP = 1024;
   localparam int TMO = 1500;
   localparam int SKIP = 2;
   localparam int P_IDLE = 0, P_ARM = 1, P_START = 2, P_RUN = 3;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ctrl_we = 1'b0, ctrl_wdata = 1'b0, frame_start = 1'b0, pause_n = 1'b1, pix_wr = 1'b0;
   logic compress_start, compress_req, busy, done, err_timeout;
   logic [31:0] status;
   int checks = 0, errors = 0, done_seen = 0;
   int ph = P_IDLE, skips = 0, pixels = 0, run_cycles = 0;
   bit m_start = 0, m_req = 0, m_busy = 0, m_done = 0, m_err = 0;

   compress_sequencer #(.NUM_PIXELS(NP), .TIMEOUT_CYCLES(TMO), .SKIP_FRAMES(SKIP)) dut (
      .clk(clk), .rst_n(rst_n), .ctrl_we(ctrl_we), .ctrl_wdata(ctrl_wdata),
      .frame_start(frame_start), .pause_n(pause_n), .pix_wr(pix_wr),
      .compress_start(compress_start), .compress_req(compress_req), .busy(busy),
      .done(done), .err_timeout(err_timeout), .status(status));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check(tag, {27'b0, compress_start, compress_req, busy, done, err_timeout, status},
            {27'b0, m_start, m_req, m_busy, m_done, m_err, 29'b0, m_err, m_busy, m_req});
   endtask

   task automatic model_reset();
      ph = P_IDLE; skips = 0; pixels = 0; run_cycles = 0;
      {m_start, m_req, m_busy, m_done, m_err} = '0;
   endtask

   task automatic model(input bit we, input bit wd, input bit fs, input bit pn, input bit pw);
      m_start = 0;
      m_done = 0;
      if (ph == P_IDLE) begin
         if (we && wd) begin ph = P_ARM; m_req = 1; m_err = 0; skips = SKIP; end
      end else if (ph == P_ARM) begin
         if (we && !wd) begin ph = P_IDLE; m_req = 0; end
         else if (fs && pn) begin
            if (skips > 0) skips--;
            else begin ph = P_START; m_start = 1; end
         end
      end else begin
         if (ph == P_START) begin pixels = 0; run_cycles = 0; end
         else run_cycles++;
         pixels += int'(pw);
         if (pixels == NP) begin ph = P_IDLE; m_done = 1; m_req = 0; end
         else if (we && !wd) begin ph = P_IDLE; m_req = 0; end
         else if (run_cycles == TMO) begin ph = P_IDLE; m_req = 0; m_err = 1; end
         else ph = P_RUN;
      end
      m_busy = (ph == P_START) || (ph == P_RUN);
   endtask

   task automatic step(input bit we, input bit wd, input bit fs, input bit pn, input bit pw);
      ctrl_we = we; ctrl_wdata = wd; frame_start = fs; pause_n = pn; pix_wr = pw;
      model(we, wd, fs, pn, pw);
      @(posedge clk);
      #1;
      done_seen += int'(done);
      check_outputs("cycle");
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 1, 0);
   endtask

   task automatic arm_start();
      step(1, 1, 0, 1, 0);
      idle($urandom_range(3));
      for (int i = 0; i <= SKIP; i++) begin
         step(0, 0, 1, 1, 0);
         if (i < SKIP) idle($urandom_range(1, 4));
      end
   endtask

   task automatic feed(input int n, input bit dense);
      int sent = 0;
      bit p;
      for (int k = 0; k < 20000 && sent < n; k++) begin
         p = dense || ($urandom_range(3) != 0);
         step(0, 0, $urandom_range(7) == 0, $urandom_range(5) != 0, p);
         sent += int'(p);
      end
      if (sent < n) begin
         checks++; errors++;
         $error("FAIL feed_bound: observed %0d strobes expected %0d", sent, n);
      end
   endtask

   task automatic wait_req_low(input int max);
      int k = 0;
      while (compress_req && k < max) begin idle(1); k++; end
      check("req_low_bound", {63'b0, compress_req}, 64'd0);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      // full compression with random strobe gaps, then stray strobes in IDLE
      done_seen = 0;
      arm_start();
      feed(NP, 0);
      check("full_done_count", done_seen, 1);
      check("full_status", status, 0);
      repeat (3) step(0, 0, 0, 1, 1);

      // frames while paused neither start nor consume a skip
      step(1, 1, 0, 1, 0);
      step(0, 0, 1, 0, 0);
      idle(2);
      step(0, 0, 1, 0, 0);
      idle(1);
      for (int i = 0; i < SKIP; i++) begin step(0, 0, 1, 1, 0); idle(2); end
      check("pause_no_start", {62'b0, busy, compress_req}, 64'd1);
      step(0, 0, 1, 1, 0);
      check("pause_start", {63'b0, compress_start}, 64'd1);
      step(1, 0, 0, 1, 0);
      check("start_abort", {62'b0, busy, compress_req}, 64'd0);

      // timeout after a few strobes, then re-arm clears the flag
      done_seen = 0;
      arm_start();
      feed(10, 0);
      wait_req_low(TMO + 50);
      check("timeout_err", {63'b0, err_timeout}, 64'd1);
      check("timeout_no_done", done_seen, 0);
      idle(2);
      step(1, 1, 0, 1, 0);
      check("rearm_clears_err", {63'b0, err_timeout}, 64'd0);
      step(1, 0, 0, 1, 0);

      // abort mid-run; a write 1 while running is ignored
      done_seen = 0;
      arm_start();
      feed(250, 0);
      step(1, 1, 0, 1, 1);
      feed(249, 0);
      step(1, 0, 0, 1, 0);
      check("abort_req", {62'b0, busy, compress_req}, 64'd0);
      check("abort_no_done", done_seen, 0);

      // abort on the completing strobe: completion wins
      arm_start();
      feed(NP - 1, 0);
      step(1, 0, 0, 1, 1);
      check("abort_vs_done", {63'b0, done}, 64'd1);

      // completing strobe on the timeout cycle: completion wins
      arm_start();
      feed(NP - 1, 1);
      while (ph == P_RUN && run_cycles < TMO - 1) idle(1);
      step(0, 0, 0, 1, 1);
      check("timeout_vs_done", {62'b0, done, err_timeout}, 64'd2);

      // abort on the timeout cycle: abort wins, no error
      arm_start();
      feed(10, 1);
      while (ph == P_RUN && run_cycles < TMO - 1) idle(1);
      step(1, 0, 0, 1, 0);
      check("abort_vs_timeout", {62'b0, err_timeout, compress_req}, 64'd0);

      // asynchronous reset mid-run, then re-arm amid trailing strobes
      arm_start();
      feed(300, 0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");
      @(posedge clk);
      #1;
      check_outputs("reset_held");
      rst_n = 1'b1;
      repeat (2) step(0, 0, 0, 1, 1);
      step(1, 1, 0, 1, 1);
      repeat (2) step(0, 0, 0, 1, 1);
      for (int i = 0; i <= SKIP; i++) step(0, 0, 1, 1, 1);
      done_seen = 0;
      feed(NP, 0);
      check("post_reset_done", done_seen, 1);
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
